// File: rtl/mod_up_down_counter_if.sv
// Control/status bundle for mod_up_down_counter; the sat line exists only
// when MOD_UP_DOWN_COUNTER_SAT_EN is defined.
interface mod_up_down_counter_if #(
    parameter int N = 8
);
    logic         en_b;
    logic         cin_b;
    logic         load_b;
    logic         up;
    logic [N-1:0] load_in;
    logic [N-1:0] max_in;
    logic [N-1:0] q;
    logic         rco_b;
    logic         wrap;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
    logic         sat;
`endif

    modport master (
        output en_b, cin_b, load_b, up, load_in, max_in,
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
        output sat,
`endif
        input  q, rco_b, wrap
    );

    modport slave (
        input  en_b, cin_b, load_b, up, load_in, max_in,
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
        input  sat,
`endif
        output q, rco_b, wrap
    );
endinterface

// File: rtl/mod_up_down_counter.sv
// Cascadable modulus up/down counter with load, ripple carry and wrap pulse.
// Optional saturating mode is compiled in with MOD_UP_DOWN_COUNTER_SAT_EN.
module mod_up_down_counter #(
    parameter int N       = 8,
    parameter int RST_VAL = 0
) (
    input  logic                      clk,
    input  logic                      rst_b,
    mod_up_down_counter_if.slave      bus
);

    logic [N-1:0] q_r;
    logic         wrap_r;
    logic [N-1:0] q_next_s;
    logic         wrap_next_s;
    logic [N-1:0] step_val_s;
    logic [N-1:0] wrap_val_s;
    logic         term_s;

    // >= on the up side lets an over-range load terminate immediately
    function automatic logic term_f(input logic [N-1:0] val,
                                    input logic [N-1:0] max_val,
                                    input logic         dir_up);
        return dir_up ? (val >= max_val) : (val == {N{1'b0}});
    endfunction

    assign term_s     = term_f(q_r, bus.max_in, bus.up);
    assign step_val_s = bus.up ? (q_r + {{(N-1){1'b0}}, 1'b1})
                               : (q_r - {{(N-1){1'b0}}, 1'b1});
    assign wrap_val_s = bus.up ? {N{1'b0}} : bus.max_in;

    // Next-state selection in priority order: enable, load, cascade, count
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        if (bus.en_b) begin
            q_next_s = q_r;
        end else if (!bus.load_b) begin
            q_next_s = bus.load_in;
        end else if (bus.cin_b) begin
            q_next_s = q_r;
        end else if (term_s) begin
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
            if (bus.sat) begin
                q_next_s    = q_r;
                wrap_next_s = 1'b0;
            end else begin
                q_next_s    = wrap_val_s;
                wrap_next_s = 1'b1;
            end
`else
            q_next_s    = wrap_val_s;
            wrap_next_s = 1'b1;
`endif
        end else begin
            q_next_s = step_val_s;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
            // saturating: pulse on the count that arrives at the terminal
            wrap_next_s = bus.sat & term_f(step_val_s, bus.max_in, bus.up);
`else
            wrap_next_s = 1'b0;
`endif
        end
    end

    // Counter and wrap-pulse registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_r    <= N'(RST_VAL);
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign bus.q     = q_r;
    assign bus.wrap  = wrap_r;
    assign bus.rco_b = ~(term_s & ~bus.en_b & ~bus.cin_b);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Randomized + directed bench for two cascaded mod_up_down_counter stages
// against an integer reference model.
module tb_mod_up_down_counter;

    localparam int N = 4;

    logic clk;
    logic rst_b;
    int   checks;
    int   failures;

    int   mq0, mq1;
    bit   mw0, mw1;
    bit   sat0;

    mod_up_down_counter_if #(.N(N)) if0 ();
    mod_up_down_counter_if #(.N(N)) if1 ();

    assign if1.cin_b = if0.rco_b;
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
    assign if0.sat = sat0;
    assign if1.sat = 1'b0;
`endif

    mod_up_down_counter #(.N(N), .RST_VAL(0)) u_stage0 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if0.slave)
    );

    mod_up_down_counter #(.N(N), .RST_VAL(0)) u_stage1 (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_term(input int q, input int mx, input bit dir_up);
        return dir_up ? (q >= mx) : (q == 0);
    endfunction

    task automatic m_step(input int q, input int mx, input bit en_b, input bit ld_b,
                          input bit cin_b, input bit dir_up, input bit sat,
                          input int ldin, output int nq, output bit nw);
        nq = q;
        nw = 1'b0;
        if (en_b) begin
            nq = q;
        end else if (!ld_b) begin
            nq = ldin;
        end else if (cin_b) begin
            nq = q;
        end else if (m_term(q, mx, dir_up)) begin
            nq = sat ? q : (dir_up ? 0 : mx);
            nw = !sat;
        end else begin
            nq = dir_up ? q + 1 : q - 1;
            nw = sat && m_term(nq, mx, dir_up);
        end
    endtask

    // One clock: check carries before the edge, then state after it
    task automatic tick();
        bit r0, r1;
        int nq0, nq1;
        bit nw0, nw1;
        #1;
        r0 = !(m_term(mq0, int'(if0.max_in), if0.up) && !if0.en_b && !if0.cin_b);
        r1 = !(m_term(mq1, int'(if1.max_in), if1.up) && !if1.en_b && !r0);
        check_eq("rco0", int'(if0.rco_b), int'(r0));
        check_eq("rco1", int'(if1.rco_b), int'(r1));
        m_step(mq0, int'(if0.max_in), if0.en_b, if0.load_b, if0.cin_b, if0.up,
               sat0, int'(if0.load_in), nq0, nw0);
        m_step(mq1, int'(if1.max_in), if1.en_b, if1.load_b, r0, if1.up,
               1'b0, int'(if1.load_in), nq1, nw1);
        @(posedge clk);
        mq0 = nq0; mw0 = nw0; mq1 = nq1; mw1 = nw1;
        #1;
        check_eq("q0", int'(if0.q), mq0);
        check_eq("wrap0", int'(if0.wrap), int'(mw0));
        check_eq("q1", int'(if1.q), mq1);
        check_eq("wrap1", int'(if1.wrap), int'(mw1));
    endtask

    task automatic set0(input bit en_b, input bit ld_b, input bit cin_b, input bit dir_up,
                        input int ldin, input int mx);
        if0.en_b    = en_b;
        if0.load_b  = ld_b;
        if0.cin_b   = cin_b;
        if0.up      = dir_up;
        if0.load_in = N'(ldin);
        if0.max_in  = N'(mx);
    endtask

    task automatic set1(input bit en_b, input bit ld_b, input bit dir_up,
                        input int ldin, input int mx);
        if1.en_b    = en_b;
        if1.load_b  = ld_b;
        if1.up      = dir_up;
        if1.load_in = N'(ldin);
        if1.max_in  = N'(mx);
    endtask

    initial begin
        checks = 0; failures = 0;
        mq0 = 0; mq1 = 0; mw0 = 1'b0; mw1 = 1'b0; sat0 = 1'b0;
        rst_b = 1'b0;
        set0(1'b1, 1'b1, 1'b1, 1'b1, 0, 9);
        set1(1'b1, 1'b1, 1'b1, 0, 15);
        repeat (2) @(negedge clk);
        check_eq("rst_q0", int'(if0.q), 0);
        check_eq("rst_wrap0", int'(if0.wrap), 0);
        rst_b = 1'b1;
        @(posedge clk); #1;

        // async reset mid-count at q=6
        set0(1'b0, 1'b1, 1'b0, 1'b1, 0, 9);
        repeat (6) tick();
        check_eq("pre_rst_q", int'(if0.q), 6);
        #2 rst_b = 1'b0;
        #1;
        check_eq("async_q", int'(if0.q), 0);
        check_eq("async_wrap", int'(if0.wrap), 0);
        mq0 = 0; mw0 = 1'b0; mq1 = 0; mw1 = 1'b0;
        #2 rst_b = 1'b1;
        repeat (3) tick();
        check_eq("post_rst_q", int'(if0.q), 3);

        // modulus-10 up: 12 edges from 0
        set0(1'b0, 1'b0, 1'b0, 1'b1, 0, 9);
        tick();
        set0(1'b0, 1'b1, 1'b0, 1'b1, 0, 9);
        repeat (12) tick();
        check_eq("up12_q", int'(if0.q), 2);

        // modulus-6 down from 0
        set0(1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
        tick();
        set0(1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
        tick();
        check_eq("down_wrap_q", int'(if0.q), 5);
        check_eq("down_wrap_w", int'(if0.wrap), 1);
        repeat (5) tick();

        // load priority and over-range value
        set0(1'b0, 1'b0, 1'b1, 1'b1, 3, 9);
        tick();
        set0(1'b0, 1'b0, 1'b1, 1'b1, 12, 9);
        tick();
        check_eq("load_over", int'(if0.q), 12);
        set0(1'b0, 1'b1, 1'b0, 1'b1, 12, 9);
        tick();
        check_eq("over_wrap_q", int'(if0.q), 0);
        check_eq("over_wrap_w", int'(if0.wrap), 1);
        set0(1'b1, 1'b0, 1'b0, 1'b1, 7, 9);
        tick();
        check_eq("en_blocks_load", int'(if0.q), 0);

        // cascade {hi,lo} = {1,15} -> {2,0}, then freeze
        set0(1'b0, 1'b0, 1'b1, 1'b1, 15, 15);
        set1(1'b0, 1'b0, 1'b1, 1, 15);
        tick();
        set0(1'b0, 1'b1, 1'b0, 1'b1, 0, 15);
        set1(1'b0, 1'b1, 1'b1, 0, 15);
        tick();
        check_eq("casc_lo", int'(if0.q), 0);
        check_eq("casc_hi", int'(if1.q), 2);
        set0(1'b0, 1'b1, 1'b1, 1'b1, 0, 15);
        repeat (2) tick();
        check_eq("frz_hi", int'(if1.q), 2);

`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
        // saturating up from 5 to max 7, then step down
        sat0 = 1'b1;
        set1(1'b1, 1'b1, 1'b1, 0, 15);
        set0(1'b0, 1'b0, 1'b0, 1'b1, 5, 7);
        tick();
        set0(1'b0, 1'b1, 1'b0, 1'b1, 0, 7);
        repeat (5) tick();
        check_eq("sat_hold", int'(if0.q), 7);
        set0(1'b0, 1'b1, 1'b0, 1'b0, 0, 7);
        tick();
        check_eq("sat_down", int'(if0.q), 6);
`endif

        // randomized traffic on both stages
        for (int i = 0; i < 400; i++) begin
            set0($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
                 1'($urandom_range(1)), $urandom_range(15),
                 ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(15));
            set1($urandom_range(7) == 0, $urandom_range(31) == 0, 1'($urandom_range(1)),
                 $urandom_range(15), $urandom_range(15));
`ifdef MOD_UP_DOWN_COUNTER_SAT_EN
            sat0 = 1'($urandom_range(1));
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
